// File: rtl/code_loader.sv
// code_loader: fills a 16-bit code memory from an 8-bit big-endian byte
// stream, then releases the core by raising run. All outputs come from flops.
module code_loader #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              code_w_en,
    output logic [ADDR_W-1:0] code_addr,
    output logic [15:0]       code_data,
    output logic              run,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WR,
        S_RUN
    } state_t;

    // Capacity in words; requested lengths above this are clamped so the
    // address counter never wraps.
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         data_q, data_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                done_q, done_d;
    logic                run_q, run_d;
    logic                busy_q, busy_d;
    logic                wen_q, wen_d;
    logic                rdy_q, rdy_d;
    logic                hs;

    // Next-state logic; abort beats load_start, and output flops are loaded
    // from the next state so every output is a clean register.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        len_d   = len_q;
        done_d  = 1'b0;
        hs      = byte_valid && rdy_q;

        if (abort && (state_q != S_IDLE)) begin
            // A WR in flight has already strobed this cycle; just leave.
            state_d = S_IDLE;
        end else if (load_start && ((state_q == S_IDLE) || (state_q == S_RUN))) begin
            addr_d = '0;
            len_d  = (load_len > CAP) ? CAP : load_len;
            if (len_d == '0) begin
                state_d = S_RUN;
                done_d  = 1'b1;
            end else begin
                state_d = S_HI;
            end
        end else begin
            case (state_q)
                S_HI: if (hs) begin
                    data_d[15:8] = byte_data;
                    state_d      = S_LO;
                end
                S_LO: if (hs) begin
                    data_d[7:0] = byte_data;
                    state_d     = S_WR;
                end
                S_WR: begin
                    if ({1'b0, addr_q} == (len_q - ONE)) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_HI;
                    end
                end
                default: ;
            endcase
        end

        rdy_d  = (state_d == S_HI) || (state_d == S_LO);
        wen_d  = (state_d == S_WR);
        busy_d = (state_d == S_HI) || (state_d == S_LO) || (state_d == S_WR);
        run_d  = (state_d == S_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            wen_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            len_q   <= len_d;
            done_q  <= done_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            wen_q   <= wen_d;
            rdy_q   <= rdy_d;
        end
    end

    assign byte_ready = rdy_q;
    assign code_w_en  = wen_q;
    assign code_addr  = addr_q;
    assign code_data  = data_q;
    assign run        = run_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_code_loader.sv
// Bench for code_loader: per-cycle comparison against a mode/byte-count
// reference model, plus directed loads with literal expectations.
module tb_code_loader;

    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;
    typedef logic [AW:0] len_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    len_t          load_len = '0;
    logic          abort = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready, code_w_en, run, busy, done;
    logic [AW-1:0] code_addr;
    logic [15:0]   code_data;

    always #5 clk = ~clk;

    code_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .code_w_en(code_w_en), .code_addr(code_addr),
        .code_data(code_data), .run(run), .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 loading, 2 running; within a load it
    // counts bytes of the current word and flags the write cycle.
    int          m_mode = 0, m_nb = 0, m_addr = 0, m_len = 0;
    bit          m_wr = 0, m_done = 0;
    logic [15:0] m_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_wr = 0; m_nb = 0; m_addr = 0; m_len = 0; m_done = 0; m_data = '0;
        end else begin
            m_done = 0;
            if (abort && m_mode != 0) begin
                m_mode = 0; m_wr = 0; m_nb = 0;
            end else if (load_start && m_mode != 1) begin
                m_len  = (int'(load_len) > DEPTH) ? DEPTH : int'(load_len);
                m_addr = 0; m_nb = 0; m_wr = 0;
                if (m_len == 0) begin m_mode = 2; m_done = 1; end
                else m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_wr) begin
                    m_wr = 0;
                    if (m_addr == m_len - 1) begin m_mode = 2; m_done = 1; end
                    else m_addr++;
                end else if (byte_valid) begin
                    if (m_nb == 0) begin m_data[15:8] = byte_data; m_nb = 1; end
                    else begin m_data[7:0] = byte_data; m_nb = 0; m_wr = 1; end
                end
            end
        end
    end

    // Write log taken from the DUT for the directed literal checks.
    logic [15:0] wmem [DEPTH];
    int wcount = 0, done_cnt = 0, first_addr = -1, last_addr = -1;

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("byte_ready", 32'(byte_ready), 32'(m_mode == 1 && !m_wr));
            chk("code_w_en",  32'(code_w_en),  32'(m_wr));
            chk("busy",       32'(busy),       32'(m_mode == 1));
            chk("run",        32'(run),        32'(m_mode == 2));
            chk("done",       32'(done),       32'(m_done));
            chk("code_addr",  32'(code_addr),  32'(m_addr));
            chk("code_data",  32'(code_data),  32'(m_data));
            if (code_w_en) begin
                wmem[code_addr] = code_data;
                wcount++;
                last_addr = int'(code_addr);
                if (first_addr < 0) first_addr = int'(code_addr);
            end
            if (done) done_cnt++;
        end
    end

    logic [7:0] q[$];
    int phase = 0;

    task automatic clr();
        wcount = 0; done_cnt = 0; first_addr = -1; last_addr = -1;
        for (int i = 0; i < DEPTH; i++) wmem[i] = '0;
    endtask

    // One cycle of byte streaming; pat 0 = always valid, 1 = 1,0,0 pattern.
    task automatic step(input int pat);
        bit v;
        @(negedge clk);
        rst = 0; load_start = 0; abort = 0;
        v = (pat == 0) ? 1'b1 : (phase % 3 == 0);
        phase++;
        if (q.size() == 0) v = 0;
        byte_valid = v;
        byte_data  = v ? q[0] : 8'($urandom);
        if (v && byte_ready) void'(q.pop_front());
    endtask

    task automatic start(input int len);
        @(negedge clk);
        rst = 0; abort = 0; byte_valid = 0;
        load_start = 1; load_len = len_t'(len);
    endtask

    task automatic wait_run(input int pat, input int budget, input string nm);
        int c = 0;
        do begin step(pat); c++; end while (!run && c < budget);
        if (!run) chk({nm, "_timeout"}, 0, 1);
        step(pat);
    endtask

    initial begin
        rst = 1;
        @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("rst_run", 32'(run), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(code_data), 0);
        step(0);

        // Basic load, continuous bytes.
        clr(); q = '{8'hA8, 8'h05, 8'hC0, 8'h12};
        start(2); wait_run(0, 50, "basic");
        chk("basic_wcount", wcount, 2);
        chk("basic_w0", 32'(wmem[0]), 32'hA805);
        chk("basic_w1", 32'(wmem[1]), 32'hC012);
        chk("basic_done", done_cnt, 1);
        chk("basic_last", last_addr, 1);

        // Same stream with backpressure, reloaded from RUN.
        clr(); q = '{8'hA8, 8'h05, 8'hC0, 8'h12}; phase = 0;
        start(2); wait_run(1, 100, "bp");
        chk("bp_wcount", wcount, 2);
        chk("bp_w0", 32'(wmem[0]), 32'hA805);
        chk("bp_w1", 32'(wmem[1]), 32'hC012);
        chk("bp_qleft", q.size(), 0);

        // Abort while waiting for the low byte of the second word.
        clr(); q = '{8'h11, 8'h22, 8'h33};
        start(3);
        repeat (8) step(0);
        @(negedge clk); load_start = 0; byte_valid = 0; abort = 1;
        step(0); step(0);
        chk("abort_wcount", wcount, 1);
        chk("abort_w0", 32'(wmem[0]), 32'h1122);
        chk("abort_done", done_cnt, 0);
        chk("abort_run", 32'(run), 0);
        chk("abort_busy", 32'(busy), 0);

        // Clamp to capacity: 600 requested, 512 written.
        clr(); q.delete();
        for (int i = 0; i < 1200; i++) q.push_back(8'($urandom));
        start(600); wait_run(0, 2000, "sat");
        chk("sat_wcount", wcount, 512);
        chk("sat_last", last_addr, 32'h1FF);
        chk("sat_qleft", q.size(), 176);
        repeat (5) step(0);
        chk("sat_noaccept", q.size(), 176);
        q.delete();

        // Reload from RUN with one word.
        clr(); q = '{8'hDE, 8'hAD};
        start(1); wait_run(0, 50, "reload");
        chk("reload_wcount", wcount, 1);
        chk("reload_w0", 32'(wmem[0]), 32'hDEAD);

        // Zero length: straight to RUN with a done pulse.
        clr();
        start(0); step(0); step(0); step(0);
        chk("zero_wcount", wcount, 0);
        chk("zero_done", done_cnt, 1);
        chk("zero_run", 32'(run), 1);

        // Reset during WR, then a fresh load starts at address 0.
        clr(); q = '{8'h01, 8'h02, 8'h03, 8'h04};
        start(2);
        begin
            int c = 0;
            do begin step(0); c++; end while (!code_w_en && c < 20);
            if (!code_w_en) chk("rst_wr_timeout", 0, 1);
        end
        rst = 1; byte_valid = 0;
        step(0);
        chk("rstwr_busy", 32'(busy), 0);
        chk("rstwr_wen", 32'(code_w_en), 0);
        chk("rstwr_addr", 32'(code_addr), 0);
        chk("rstwr_data", 32'(code_data), 0);
        clr(); q = '{8'h77, 8'h88};
        start(1); wait_run(0, 50, "after_rst");
        chk("after_rst_first", first_addr, 0);
        chk("after_rst_w0", 32'(wmem[0]), 32'h7788);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst        = ($urandom % 800 == 0);
            load_start = ($urandom % 30 == 0);
            abort      = !load_start && ($urandom % 120 == 0);
            load_len   = ($urandom % 8 == 0) ? len_t'($urandom) : len_t'($urandom % 12);
            byte_valid = ($urandom % 4) != 0;
            byte_data  = 8'($urandom);
        end
        @(negedge clk);
        rst = 0; load_start = 0; abort = 0; byte_valid = 0;
        step(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
